// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, RGB565 colours, default 640x480 timing
// and the sync-flag bundle passed from the timing core.
package vga_pkg;

   localparam int unsigned RGB_W = 16;

   localparam int unsigned DEF_H_SYNC  = 96;
   localparam int unsigned DEF_H_BACK  = 48;
   localparam int unsigned DEF_H_VALID = 640;
   localparam int unsigned DEF_H_FRONT = 16;
   localparam int unsigned DEF_V_SYNC  = 2;
   localparam int unsigned DEF_V_BACK  = 33;
   localparam int unsigned DEF_V_VALID = 480;
   localparam int unsigned DEF_V_FRONT = 10;
   localparam int unsigned DEF_CNT_W   = 12;
   localparam int unsigned DEF_SQ_SIZE = 32;

   typedef enum logic [1:0] {
      MODE_COLORBAR = 2'd0,
      MODE_GRID     = 2'd1,
      MODE_GRADIENT = 2'd2,
      MODE_SQUARE   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_e;

   typedef logic [RGB_W-1:0] rgb565_t;

   localparam rgb565_t RGB_BLACK   = 16'h0000;
   localparam rgb565_t RGB_RED     = 16'hF800;
   localparam rgb565_t RGB_ORANGE  = 16'hFC00;
   localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
   localparam rgb565_t RGB_GREEN   = 16'h07E0;
   localparam rgb565_t RGB_CYAN    = 16'h07FF;
   localparam rgb565_t RGB_BLUE    = 16'h001F;
   localparam rgb565_t RGB_MAGENTA = 16'hF81F;
   localparam rgb565_t RGB_WHITE   = 16'hFFFF;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic frame_start;
   } sync_t;

   // Colour of colorbar stripe idx, left to right.
   function automatic rgb565_t bar_color(input logic [2:0] idx);
      rgb565_t c;
      case (idx)
         3'd0:    c = RGB_RED;
         3'd1:    c = RGB_ORANGE;
         3'd2:    c = RGB_YELLOW;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_CYAN;
         3'd5:    c = RGB_BLUE;
         3'd6:    c = RGB_MAGENTA;
         default: c = RGB_WHITE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters, sync, active-video and pixel coordinates.
// Combinational _c views feed the pattern logic so its registered colour lines up.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned H_VALID = DEF_H_VALID,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK,
   parameter int unsigned V_VALID = DEF_V_VALID,
   parameter int unsigned V_FRONT = DEF_V_FRONT,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             active_c_o,
   output logic             frame_first_c_o,
   output logic [CNT_W-1:0] pix_x_c_o,
   output logic [CNT_W-1:0] pix_y_c_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o,
   output logic             frame_start_o,
   output logic [CNT_W-1:0] pix_x_o,
   output logic [CNT_W-1:0] pix_y_o
);

   localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
   localparam int unsigned H_ACT_END   = H_ACT_START + H_VALID;
   localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
   localparam int unsigned V_ACT_END   = V_ACT_START + V_VALID;

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] pix_x_q, pix_y_q;
   logic             h_wrap_c, h_act_c, v_act_c;
   sync_t            sync_d, sync_q;

   always_comb begin
      h_wrap_c = (h_cnt_q == CNT_W'(H_TOTAL - 1));
      h_cnt_d  = h_wrap_c ? '0 : h_cnt_q + CNT_W'(1);
      v_cnt_d  = v_cnt_q;
      if (h_wrap_c) begin
         v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
      end

      h_act_c = (h_cnt_q >= CNT_W'(H_ACT_START)) && (h_cnt_q < CNT_W'(H_ACT_END));
      v_act_c = (v_cnt_q >= CNT_W'(V_ACT_START)) && (v_cnt_q < CNT_W'(V_ACT_END));

      active_c_o      = h_act_c && v_act_c;
      frame_first_c_o = (h_cnt_q == '0) && (v_cnt_q == '0);
      pix_x_c_o       = active_c_o ? h_cnt_q - CNT_W'(H_ACT_START) : '0;
      pix_y_c_o       = active_c_o ? v_cnt_q - CNT_W'(V_ACT_START) : '0;

      sync_d.hsync       = (h_cnt_q < CNT_W'(H_SYNC));
      sync_d.vsync       = (v_cnt_q < CNT_W'(V_SYNC));
      sync_d.de          = active_c_o;
      sync_d.frame_start = frame_first_c_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         sync_q  <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         sync_q  <= sync_d;
         pix_x_q <= pix_x_c_o;
         pix_y_q <= pix_y_c_o;
      end
   end

   assign hsync_o       = sync_q.hsync;
   assign vsync_o       = sync_q.vsync;
   assign de_o          = sync_q.de;
   assign frame_start_o = sync_q.frame_start;
   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colorbar, grid, gradient and a bouncing square,
// with pattern mode and square position latched once per frame.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned H_VALID = DEF_H_VALID,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK,
   parameter int unsigned V_VALID = DEF_V_VALID,
   parameter int unsigned V_FRONT = DEF_V_FRONT,
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned SQ_SIZE = DEF_SQ_SIZE
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   input  logic [1:0]       mode,
   output logic [15:0]      rgb,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             frame_start
);

   localparam int unsigned BAR_W   = H_VALID / 8;
   localparam int unsigned BAR_END = 8 * BAR_W;
   localparam int unsigned X_MAX   = H_VALID - SQ_SIZE;
   localparam int unsigned Y_MAX   = V_VALID - SQ_SIZE;

   logic             active_c, frame_first_c;
   logic [CNT_W-1:0] pix_x_c, pix_y_c;
   logic [4:0]       grad_c;

   mode_e            mode_q, mode_d;
   dir_e             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [CNT_W-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
   rgb565_t          rgb_q, rgb_d;

   vga_timing #(
      .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_VALID(H_VALID), .H_FRONT(H_FRONT),
      .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_VALID(V_VALID), .V_FRONT(V_FRONT),
      .CNT_W  (CNT_W)
   ) u_timing (
      .clk            (vga_clk),
      .rst_n          (sys_rst_n),
      .active_c_o     (active_c),
      .frame_first_c_o(frame_first_c),
      .pix_x_c_o      (pix_x_c),
      .pix_y_c_o      (pix_y_c),
      .hsync_o        (hsync),
      .vsync_o        (vsync),
      .de_o           (de),
      .frame_start_o  (frame_start),
      .pix_x_o        (pix_x),
      .pix_y_o        (pix_y)
   );

   // Per-frame update: latch mode and advance the square, bouncing off the edges.
   always_comb begin
      mode_d  = mode_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      sq_x_d  = sq_x_q;
      sq_y_d  = sq_y_q;
      if (frame_first_c) begin
         mode_d = mode_e'(mode);
         if (dir_x_q == DIR_POS) begin
            if (sq_x_q == CNT_W'(X_MAX)) begin
               dir_x_d = DIR_NEG;
               sq_x_d  = sq_x_q - CNT_W'(1);
            end else begin
               sq_x_d  = sq_x_q + CNT_W'(1);
            end
         end else if (sq_x_q == '0) begin
            dir_x_d = DIR_POS;
            sq_x_d  = sq_x_q + CNT_W'(1);
         end else begin
            sq_x_d  = sq_x_q - CNT_W'(1);
         end

         if (dir_y_q == DIR_POS) begin
            if (sq_y_q == CNT_W'(Y_MAX)) begin
               dir_y_d = DIR_NEG;
               sq_y_d  = sq_y_q - CNT_W'(1);
            end else begin
               sq_y_d  = sq_y_q + CNT_W'(1);
            end
         end else if (sq_y_q == '0) begin
            dir_y_d = DIR_POS;
            sq_y_d  = sq_y_q + CNT_W'(1);
         end else begin
            sq_y_d  = sq_y_q - CNT_W'(1);
         end
      end
   end

   // Pixel colour for the current counter position; blank outside active video.
   always_comb begin
      rgb_d  = RGB_BLACK;
      grad_c = pix_x_c[9:5];
      if (active_c) begin
         case (mode_q)
            MODE_COLORBAR: rgb_d = (pix_x_c >= CNT_W'(BAR_END)) ? RGB_WHITE
                                    : bar_color(3'(pix_x_c / CNT_W'(BAR_W)));
            MODE_GRID:     rgb_d = ((pix_x_c[4:0] == 5'd0) || (pix_y_c[4:0] == 5'd0) ||
                                    (pix_x_c == CNT_W'(H_VALID - 1)) ||
                                    (pix_y_c == CNT_W'(V_VALID - 1))) ? RGB_WHITE : RGB_BLACK;
            MODE_GRADIENT: rgb_d = {grad_c, grad_c, grad_c[4], grad_c};
            MODE_SQUARE:   rgb_d = ((pix_x_c >= sq_x_q) && (pix_x_c < sq_x_q + CNT_W'(SQ_SIZE)) &&
                                    (pix_y_c >= sq_y_q) && (pix_y_c < sq_y_q + CNT_W'(SQ_SIZE)))
                                    ? RGB_WHITE : RGB_BLUE;
            default:       rgb_d = RGB_BLACK;
         endcase
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q  <= MODE_COLORBAR;
         dir_x_q <= DIR_POS;
         dir_y_q <= DIR_POS;
         sq_x_q  <= '0;
         sq_y_q  <= '0;
         rgb_q   <= RGB_BLACK;
      end else begin
         mode_q  <= mode_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
         sq_x_q  <= sq_x_d;
         sq_y_q  <= sq_y_d;
         rgb_q   <= rgb_d;
      end
   end

   assign rgb = rgb_q;

endmodule
